rv32im_writeback: RTL and testbench
===================================

# rv32im_writeback

Single-port writeback arbiter and pending-register scoreboard that drives the write side of the RV32IM register file. It merges results from the ALU (fixed single-cycle, no back-pressure), load unit and multiply/divide unit (valid/ready) into one registered write per cycle. It tracks destination registers of issued long-latency instructions so decode can stall on RAW hazards.

## Interface

**Parameters**
- XLEN, 32, data width
- REG_BITS, 5, register address width; scoreboard depth is 2^REG_BITS

**Ports**
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- alu_valid_i  in  1  ALU result present this cycle; always accepted
- alu_rd_i  in  REG_BITS  ALU destination
- alu_data_i  in  XLEN  ALU result
- load_valid_i  in  1  load result offered
- load_ready_o  out  1  load result accepted this cycle
- load_rd_i  in  REG_BITS  load destination
- load_data_i  in  XLEN  load data
- muldiv_valid_i  in  1  mul/div result offered
- muldiv_ready_o  out  1  mul/div result accepted this cycle
- muldiv_rd_i  in  REG_BITS  mul/div destination
- muldiv_data_i  in  XLEN  mul/div result
- issue_i  in  1  long-latency (load/mul/div) instruction issued
- issue_rd_i  in  REG_BITS  its destination
- rs1_addr_i, rs2_addr_i  in  REG_BITS  decode source queries
- rs1_busy_o, rs2_busy_o  out  1  source not yet readable, decode must stall
- write_o  out  1  register-file write enable
- rd_addr_o  out  REG_BITS  register-file write address
- data_o  out  XLEN  register-file write data
- err_o  out  1  sticky: issue to an already-pending register
- idle_o  out  1  no pending bits and write_o low

## Operation

- **Priority:** ALU > load > mul/div. At most one acceptance per cycle.
- **Ready logic (combinational):**
  - load_ready_o = !reset_i & !alu_valid_i
  - muldiv_ready_o = !reset_i & !alu_valid_i & !load_valid_i
  - A source transfers when valid & ready. Sources hold valid/rd/data stable until accepted.
- **Output register:** the accepted transfer loads {rd_addr_o, data_o}. write_o = 1 if the accepted rd != 0, else 0, so the handshake completes but no write occurs. With no transfer, write_o = 0 and rd_addr_o/data_o hold their previous values.
- **Scoreboard:** 2^REG_BITS-bit pending vector.
  - issue_i with issue_rd_i != 0 sets pending[issue_rd_i]. issue to x0 is ignored.
  - An accepted load or mul/div transfer clears pending[rd]. ALU transfers never touch the scoreboard.
  - Set and clear of the same register in the same cycle: set wins, because the new issue supersedes the completing one.
  - issue_i to a register whose bit is already 1 (before this cycle's clear) sets err_o. err_o stays 1 until reset.
- **Busy (combinational):**
  - rsN_busy_o = (rsN != 0) & (pending[rsN] | (write_o & rd_addr_o == rsN)).
  - The in-flight term covers the register file's one-cycle write-to-read visibility.
- **idle_o** = (pending == 0) & !write_o.

## Timing

- Reset values: write_o 0, rd_addr_o 0, data_o 0, pending all 0, err_o 0, idle_o 1. Both ready outputs are 0 while reset_i is high.
- Reset mid-operation: any transfer offered during a reset cycle is not accepted. Pending bits are discarded and write_o is 0 on the following cycle.
- Latency: acceptance in cycle N produces write_o in cycle N+1. The register file captures the data at the end of N+1, and it is readable from N+2.
- Scoreboard update: an issue in cycle N gives busy = 1 from cycle N+1. A clear on acceptance in N is replaced by the in-flight term in N+1, so busy is continuous through N+1 and deasserts in N+2.
- Throughput: one write per cycle sustained. Mul/div can starve under continuous ALU/load traffic; the pipeline guarantees gaps.

## Test plan

- **ALU write:** reset, then alu_valid_i=1, rd=5, data=0xDEADBEEF for 1 cycle -> next cycle write_o=1, rd_addr_o=5, data_o=0xDEADBEEF; following cycle write_o=0.
- **Three-way contention:** alu (rd 1), load (rd 2), muldiv (rd 3) all valid in cycle 0 -> load_ready_o=0, muldiv_ready_o=0 in cycle 0. Load accepted cycle 1, muldiv cycle 2. write_o pulses at cycles 1, 2, 3 with rd 1, 2, 3.
- **Load scoreboard:** issue rd=7 in cycle 0 -> rs1_addr_i=7 busy from cycle 1. Load rd=7 accepted cycle 4 -> busy still 1 in cycle 5 (in-flight), 0 in cycle 6.
- **x0 and collision:** issue rd=0 -> no busy, idle_o stays 1. Muldiv rd=0 accepted -> muldiv_ready_o=1, write_o stays 0. Issue rd=9 in the same cycle as load rd=9 accepted -> pending[9]=1 afterwards, err_o=1.
- **Double issue:** issue rd=4 twice without completion -> err_o=1 on the cycle after the second issue, held until reset_i. After reset, err_o=0 and rs busy for 4 = 0.
- **Reset during activity:** pending {3, 8} set and load_valid_i held during the reset cycle -> load not accepted, write_o=0, all busy 0, idle_o=1 afterwards.

Source files
------------

// File: rtl/rv32im_writeback.sv
// Writeback arbiter (ALU > load > mul/div) feeding one registered register-file
// write per cycle, plus a pending-destination scoreboard for decode RAW stalls.
module rv32im_writeback #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_BITS = 5
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                alu_valid_i,
    input  logic [REG_BITS-1:0] alu_rd_i,
    input  logic [XLEN-1:0]     alu_data_i,
    input  logic                load_valid_i,
    output logic                load_ready_o,
    input  logic [REG_BITS-1:0] load_rd_i,
    input  logic [XLEN-1:0]     load_data_i,
    input  logic                muldiv_valid_i,
    output logic                muldiv_ready_o,
    input  logic [REG_BITS-1:0] muldiv_rd_i,
    input  logic [XLEN-1:0]     muldiv_data_i,
    input  logic                issue_i,
    input  logic [REG_BITS-1:0] issue_rd_i,
    input  logic [REG_BITS-1:0] rs1_addr_i,
    input  logic [REG_BITS-1:0] rs2_addr_i,
    output logic                rs1_busy_o,
    output logic                rs2_busy_o,
    output logic                write_o,
    output logic [REG_BITS-1:0] rd_addr_o,
    output logic [XLEN-1:0]     data_o,
    output logic                err_o,
    output logic                idle_o
);
    localparam int unsigned NREGS = 2 ** REG_BITS;

    logic                write_q, write_d;
    logic [REG_BITS-1:0] rd_q, rd_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic [NREGS-1:0]    pending_q, pending_d;
    logic                err_q, err_d;

    logic                any_xfer;
    logic                clr_en;
    logic                set_en;
    logic [REG_BITS-1:0] sel_rd;
    logic [XLEN-1:0]     sel_data;

    always_comb begin
        load_ready_o   = !reset_i && !alu_valid_i;
        muldiv_ready_o = !reset_i && !alu_valid_i && !load_valid_i;
    end

    always_comb begin
        any_xfer = 1'b0;
        clr_en   = 1'b0;
        sel_rd   = alu_rd_i;
        sel_data = alu_data_i;
        if (!reset_i) begin
            if (alu_valid_i) begin
                any_xfer = 1'b1;
            end else if (load_valid_i) begin
                any_xfer = 1'b1;
                clr_en   = 1'b1;
                sel_rd   = load_rd_i;
                sel_data = load_data_i;
            end else if (muldiv_valid_i) begin
                any_xfer = 1'b1;
                clr_en   = 1'b1;
                sel_rd   = muldiv_rd_i;
                sel_data = muldiv_data_i;
            end
        end

        // x0 transfers still complete the handshake but never assert the write
        write_d = any_xfer && (sel_rd != '0);
        rd_d    = any_xfer ? sel_rd : rd_q;
        data_d  = any_xfer ? sel_data : data_q;

        set_en    = issue_i && (issue_rd_i != '0);
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[sel_rd] = 1'b0;
        end
        // set after clear: a new issue supersedes a completing one
        if (set_en) begin
            pending_d[issue_rd_i] = 1'b1;
        end
        err_d = err_q || (set_en && pending_q[issue_rd_i]);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            write_q   <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            write_q   <= write_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    // in-flight term bridges the register file's write-to-read delay
    always_comb begin
        rs1_busy_o = (rs1_addr_i != '0) &&
                     (pending_q[rs1_addr_i] || (write_q && (rd_q == rs1_addr_i)));
        rs2_busy_o = (rs2_addr_i != '0) &&
                     (pending_q[rs2_addr_i] || (write_q && (rd_q == rs2_addr_i)));
        write_o    = write_q;
        rd_addr_o  = rd_q;
        data_o     = data_q;
        err_o      = err_q;
        idle_o     = (pending_q == '0) && !write_q;
    end

endmodule

// File: tb/tb_rv32im_writeback.sv
// Bench for rv32im_writeback: directed scenarios with literal expectations, then
// random traffic compared every cycle against a behavioural model.
module tb_rv32im_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_v, load_v, md_v, issue;
    logic [4:0]  alu_rd, load_rd, md_rd, issue_rd, rs1, rs2;
    logic [31:0] alu_data, load_data, md_data;
    logic        load_rdy, md_rdy, busy1, busy2, wr, err, idle;
    logic [4:0]  rd_addr;
    logic [31:0] data;

    int chk_cnt = 0;
    int err_cnt = 0;

    bit          m_pend[32];
    bit          m_write = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;
    bit          m_err = 1'b0;
    bit          m_load_acc = 1'b0;
    bit          m_md_acc = 1'b0;

    rv32im_writeback #(.XLEN(32), .REG_BITS(5)) dut (
        .clk_i(clk), .reset_i(rst),
        .alu_valid_i(alu_v), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
        .load_valid_i(load_v), .load_ready_o(load_rdy), .load_rd_i(load_rd), .load_data_i(load_data),
        .muldiv_valid_i(md_v), .muldiv_ready_o(md_rdy), .muldiv_rd_i(md_rd), .muldiv_data_i(md_data),
        .issue_i(issue), .issue_rd_i(issue_rd),
        .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rs1_busy_o(busy1), .rs2_busy_o(busy2),
        .write_o(wr), .rd_addr_o(rd_addr), .data_o(data), .err_o(err), .idle_o(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // A register is unreadable while an instruction owes it a result or while
    // its value is still being written this cycle.
    function automatic bit m_busy(input logic [4:0] r);
        return (r != 5'd0) && (m_pend[r] || (m_write && m_rd == r));
    endfunction

    function automatic bit m_idle();
        for (int i = 0; i < 32; i++) if (m_pend[i]) return 1'b0;
        return !m_write;
    endfunction

    task automatic compare();
        chk("load_ready", {31'd0, load_rdy}, {31'd0, !rst && !alu_v});
        chk("muldiv_ready", {31'd0, md_rdy}, {31'd0, !rst && !alu_v && !load_v});
        chk("write", {31'd0, wr}, {31'd0, m_write});
        chk("rd_addr", {27'd0, rd_addr}, {27'd0, m_rd});
        chk("data", data, m_data);
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("idle", {31'd0, idle}, {31'd0, m_idle()});
        chk("rs1_busy", {31'd0, busy1}, {31'd0, m_busy(rs1)});
        chk("rs2_busy", {31'd0, busy2}, {31'd0, m_busy(rs2)});
    endtask

    task automatic model_update();
        bit          hit;
        bit          clr;
        logic [4:0]  r;
        logic [31:0] d;
        hit = 1'b0; clr = 1'b0; r = '0; d = '0;
        m_load_acc = 1'b0;
        m_md_acc = 1'b0;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            m_write = 1'b0; m_rd = '0; m_data = '0; m_err = 1'b0;
        end else begin
            if (alu_v) begin
                hit = 1'b1; r = alu_rd; d = alu_data;
            end else if (load_v) begin
                hit = 1'b1; r = load_rd; d = load_data; clr = 1'b1; m_load_acc = 1'b1;
            end else if (md_v) begin
                hit = 1'b1; r = md_rd; d = md_data; clr = 1'b1; m_md_acc = 1'b1;
            end
            if (issue && issue_rd != 5'd0 && m_pend[issue_rd]) m_err = 1'b1;
            if (clr) m_pend[r] = 1'b0;
            if (issue && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
            m_write = hit && (r != 5'd0);
            if (hit) begin
                m_rd = r; m_data = d;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        rst = 1'b1; alu_v = 0; load_v = 0; md_v = 0; issue = 0;
        alu_rd = 0; load_rd = 0; md_rd = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
        alu_data = 0; load_data = 0; md_data = 0;
        @(posedge clk); #1;
        cycle();
        rst = 1'b0;
        #1;
        chk("reset_write", {31'd0, wr}, 32'd0);
        chk("reset_idle", {31'd0, idle}, 32'd1);
        chk("reset_data", data, 32'd0);

        // ALU write
        alu_v = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        cycle();
        alu_v = 0;
        chk("alu_write", {31'd0, wr}, 32'd1);
        chk("alu_rd", {27'd0, rd_addr}, 32'd5);
        chk("alu_data", data, 32'hDEADBEEF);
        cycle();
        chk("alu_write_drop", {31'd0, wr}, 32'd0);
        chk("alu_data_hold", data, 32'hDEADBEEF);

        // Three-way contention
        alu_v = 1; alu_rd = 1; alu_data = 32'h11;
        load_v = 1; load_rd = 2; load_data = 32'h22;
        md_v = 1; md_rd = 3; md_data = 32'h33;
        #1;
        chk("c0_load_ready", {31'd0, load_rdy}, 32'd0);
        chk("c0_md_ready", {31'd0, md_rdy}, 32'd0);
        cycle();
        alu_v = 0;
        #1;
        chk("c1_rd", {27'd0, rd_addr}, 32'd1);
        chk("c1_load_ready", {31'd0, load_rdy}, 32'd1);
        chk("c1_md_ready", {31'd0, md_rdy}, 32'd0);
        cycle();
        load_v = 0;
        chk("c2_rd", {27'd0, rd_addr}, 32'd2);
        chk("c2_write", {31'd0, wr}, 32'd1);
        cycle();
        md_v = 0;
        chk("c3_rd", {27'd0, rd_addr}, 32'd3);
        chk("c3_data", data, 32'h33);
        cycle();
        chk("c4_write", {31'd0, wr}, 32'd0);

        // Load scoreboard
        issue = 1; issue_rd = 7;
        cycle();
        issue = 0; rs1 = 7;
        #1;
        chk("sb_busy_c1", {31'd0, busy1}, 32'd1);
        cycle(); cycle(); cycle();
        load_v = 1; load_rd = 7; load_data = 32'h77;
        cycle();
        load_v = 0;
        #1;
        chk("sb_busy_inflight", {31'd0, busy1}, 32'd1);
        cycle();
        chk("sb_busy_clear", {31'd0, busy1}, 32'd0);

        // x0 handling
        issue = 1; issue_rd = 0;
        cycle();
        issue = 0; rs1 = 0;
        #1;
        chk("x0_idle", {31'd0, idle}, 32'd1);
        chk("x0_busy", {31'd0, busy1}, 32'd0);
        md_v = 1; md_rd = 0; md_data = 32'h55;
        #1;
        chk("x0_md_ready", {31'd0, md_rdy}, 32'd1);
        cycle();
        md_v = 0;
        chk("x0_write", {31'd0, wr}, 32'd0);

        // Same-cycle set and clear of x9
        issue = 1; issue_rd = 9;
        cycle();
        load_v = 1; load_rd = 9; load_data = 32'h99;
        cycle();
        issue = 0; load_v = 0; rs1 = 9;
        #1;
        chk("col_err", {31'd0, err}, 32'd1);
        cycle(); cycle();
        chk("col_pending", {31'd0, busy1}, 32'd1);

        // Double issue, then reset clears err
        rst = 1;
        cycle();
        rst = 0;
        chk("rst_err_clear", {31'd0, err}, 32'd0);
        issue = 1; issue_rd = 4;
        cycle();
        cycle();
        issue = 0;
        chk("dbl_err", {31'd0, err}, 32'd1);
        cycle();
        chk("dbl_err_held", {31'd0, err}, 32'd1);
        rst = 1;
        cycle();
        rst = 0; rs1 = 4;
        #1;
        chk("dbl_err_reset", {31'd0, err}, 32'd0);
        chk("dbl_busy_reset", {31'd0, busy1}, 32'd0);

        // Reset while pending and a load is offered
        issue = 1; issue_rd = 3;
        cycle();
        issue_rd = 8;
        cycle();
        issue = 0; load_v = 1; load_rd = 3; load_data = 32'h3333; rst = 1;
        #1;
        chk("rstact_load_ready", {31'd0, load_rdy}, 32'd0);
        cycle();
        rst = 0; load_v = 0; rs1 = 3; rs2 = 8;
        #1;
        chk("rstact_write", {31'd0, wr}, 32'd0);
        chk("rstact_busy1", {31'd0, busy1}, 32'd0);
        chk("rstact_busy2", {31'd0, busy2}, 32'd0);
        chk("rstact_idle", {31'd0, idle}, 32'd1);

        // Random traffic; held sources keep rd/data until accepted
        repeat (3000) begin
            rst = ($urandom_range(0, 99) == 0);
            alu_v = ($urandom_range(0, 2) == 0);
            alu_rd = 5'($urandom_range(0, 7));
            alu_data = $urandom;
            if (!load_v || m_load_acc) begin
                load_v = 1'($urandom_range(0, 1));
                load_rd = 5'($urandom_range(0, 7));
                load_data = $urandom;
            end
            if (!md_v || m_md_acc) begin
                md_v = 1'($urandom_range(0, 1));
                md_rd = 5'($urandom_range(0, 7));
                md_data = $urandom;
            end
            issue = ($urandom_range(0, 3) == 0);
            issue_rd = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
